// File: rtl/memory_round_controller.sv
// rtl/memory_round_controller.sv - memory-game round sequencer: plays back the RAM sequence, then checks player entries.
// Sole reader of the 16x4 game RAM; ram_q is expected valid in the cycle after ram_addr changes.
module memory_round_controller #(
  parameter int SHOW_CYCLES    = 1000,
  parameter int GAP_CYCLES     = 200,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int LAST_ROUND     = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       play_valid,
  input  logic [3:0] play_data,
  output logic [3:0] ram_addr,
  input  logic [3:0] ram_q,
  output logic       show_valid,
  output logic [3:0] show_data,
  output logic       await_play,
  output logic [3:0] round,
  output logic       win,
  output logic       lose,
  output logic       timeout
);

  localparam int MAX_SG  = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int MAX_ALL = (MAX_SG > TIMEOUT_CYCLES) ? MAX_SG : TIMEOUT_CYCLES;
  localparam int TW      = ($clog2(MAX_ALL) < 1) ? 1 : $clog2(MAX_ALL);

  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST_R    = 4'(LAST_ROUND);

  typedef enum logic [3:0] {
    IDLE, SHOW_FETCH, SHOW_HOLD, SHOW_GAP, PLAY_FETCH, WAIT_PLAY, NEXT_ROUND, WIN, LOSE
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      round_q, round_d;
  logic [3:0]      idx_q, idx_d;
  logic [3:0]      addr_q, addr_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            show_valid_q, show_valid_d;
  logic [3:0]      show_data_q, show_data_d;
  logic [3:0]      expected_q, expected_d;
  logic            timeout_q, timeout_d;
  logic [TW-1:0]   timer_inc;

  // Saturating so an oversized parameter set can never wrap back into a match.
  assign timer_inc = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      round_q      <= '0;
      idx_q        <= '0;
      addr_q       <= '0;
      timer_q      <= '0;
      show_valid_q <= 1'b0;
      show_data_q  <= '0;
      expected_q   <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      timer_q      <= timer_d;
      show_valid_q <= show_valid_d;
      show_data_q  <= show_data_d;
      expected_q   <= expected_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    timer_d      = timer_q;
    show_valid_d = show_valid_q;
    show_data_d  = show_data_q;
    expected_d   = expected_q;
    timeout_d    = timeout_q;
    case (state_q)
      IDLE, WIN, LOSE: begin
        if (start) begin
          round_d   = '0;
          idx_d     = '0;
          addr_d    = '0;
          timeout_d = 1'b0;
          state_d   = SHOW_FETCH;
        end
      end
      SHOW_FETCH: begin
        show_data_d  = ram_q;
        show_valid_d = 1'b1;
        timer_d      = '0;
        state_d      = SHOW_HOLD;
      end
      SHOW_HOLD: begin
        if (timer_q == SHOW_LAST) begin
          show_valid_d = 1'b0;
          show_data_d  = '0;
          timer_d      = '0;
          state_d      = SHOW_GAP;
        end else begin
          timer_d = timer_inc;
        end
      end
      SHOW_GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          if (idx_q < round_q) begin
            idx_d   = idx_q + 4'd1;
            addr_d  = idx_q + 4'd1;
            state_d = SHOW_FETCH;
          end else begin
            idx_d   = '0;
            addr_d  = '0;
            state_d = PLAY_FETCH;
          end
        end else begin
          timer_d = timer_inc;
        end
      end
      PLAY_FETCH: begin
        expected_d = ram_q;
        timer_d    = '0;
        state_d    = WAIT_PLAY;
      end
      WAIT_PLAY: begin
        timer_d = timer_inc;
        // An entry in the final timer cycle takes priority over the timeout.
        if (play_valid) begin
          if (play_data != expected_q) begin
            timeout_d = 1'b0;
            state_d   = LOSE;
          end else if (idx_q < round_q) begin
            idx_d   = idx_q + 4'd1;
            addr_d  = idx_q + 4'd1;
            state_d = PLAY_FETCH;
          end else begin
            state_d = NEXT_ROUND;
          end
        end else if (timer_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = LOSE;
        end
      end
      NEXT_ROUND: begin
        if (round_q == LAST_R) begin
          state_d = WIN;
        end else begin
          round_d = round_q + 4'd1;
          idx_d   = '0;
          addr_d  = '0;
          state_d = SHOW_FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ram_addr   = addr_q;
  assign show_valid = show_valid_q;
  assign show_data  = show_data_q;
  assign await_play = (state_q == WAIT_PLAY);
  assign round      = round_q;
  assign win        = (state_q == WIN);
  assign lose       = (state_q == LOSE);
  assign timeout    = (state_q == LOSE) && timeout_q;

endmodule

// File: tb/tb_memory_round_controller.sv
// tb/tb_memory_round_controller.sv - scoreboard bench for memory_round_controller (params 4/2/20, last round 3).
module tb_memory_round_controller;

  localparam int SHOW = 4;
  localparam int GAP  = 2;
  localparam int TOUT = 20;
  localparam int LAST = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       play_valid = 1'b0;
  logic [3:0] play_data = '0;
  logic [3:0] ram_addr;
  logic [3:0] ram_q;
  logic       show_valid;
  logic [3:0] show_data;
  logic       await_play;
  logic [3:0] round;
  logic       win;
  logic       lose;
  logic       timeout;

  logic [3:0] mem [16];
  logic [3:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ram_q = mem[ram_addr];

  memory_round_controller #(
    .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TOUT), .LAST_ROUND(LAST)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .play_valid(play_valid), .play_data(play_data),
    .ram_addr(ram_addr), .ram_q(ram_q), .show_valid(show_valid), .show_data(show_data),
    .await_play(await_play), .round(round), .win(win), .lose(lose), .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_round(input int r);
    for (int i = 0; i <= r; i++) exp_q.push_back(mem[i]);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_await();
    int n = 0;
    while (!await_play && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!await_play) chk("await_bound", 0, 1);
  endtask

  // Drives one entry on the first WAIT_PLAY cycle; returns one cycle later.
  task automatic enter(input logic [3:0] v);
    wait_await();
    play_valid = 1'b1;
    play_data  = v;
    @(negedge clk);
    play_valid = 1'b0;
    play_data  = '0;
  endtask

  // Display monitor: every shown value is popped from the scoreboard and its length measured.
  initial begin
    logic prev = 1'b0;
    int   run  = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b0;
        run  = 0;
      end else begin
        if (show_valid && !prev) begin
          if (exp_q.size() == 0) chk("show_unexpected", {28'd0, show_data}, 32'hFFFF_FFFF);
          else chk("show_data", {28'd0, show_data}, {28'd0, exp_q.pop_front()});
          run = 1;
        end else if (show_valid) begin
          run++;
        end else if (prev) begin
          chk("show_len", run, SHOW);
        end
        if (!show_valid) chk("show_blank", {28'd0, show_data}, 0);
        prev = show_valid;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (mem[i]) mem[i] = '0;
    mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100; mem[3] = 4'b1000;

    // reset state
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_addr", {28'd0, ram_addr}, 0);
    chk("rst_round", {28'd0, round}, 0);
    chk("rst_flags", {26'd0, show_valid, await_play, win, lose, timeout, 1'b0}, 0);

    // 1: reset mid SHOW_HOLD clears asynchronously
    push_round(0);
    pulse_start();
    repeat (3) @(negedge clk);
    chk("t1_showing", {31'd0, show_valid}, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t1_async_sv", {31'd0, show_valid}, 0);
    chk("t1_async_round", {28'd0, round}, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    exp_q.delete();
    repeat (10) @(negedge clk);
    chk("t1_idle", {29'd0, show_valid, await_play, lose}, 0);

    // 2 + 6: round 0 with ignored strobes during show, then advance to round 1
    push_round(0);
    pulse_start();
    @(negedge clk);
    play_valid = 1'b1; play_data = 4'b0001;
    @(negedge clk);
    play_valid = 1'b0; play_data = '0;
    chk("t6_hold_round", {28'd0, round}, 0);
    chk("t6_hold_sv", {31'd0, show_valid}, 1);
    repeat (3) @(negedge clk);
    play_valid = 1'b1; play_data = 4'b0100;
    @(negedge clk);
    play_valid = 1'b0; play_data = '0;
    chk("t6_gap_lose", {31'd0, lose}, 0);
    push_round(1);
    enter(4'b0001);
    wait_await();
    chk("t2_round1", {28'd0, round}, 1);

    // 3: wrong second entry
    enter(4'b0001);
    enter(4'b0100);
    chk("t3_lose", {31'd0, lose}, 1);
    chk("t3_timeout", {31'd0, timeout}, 0);
    chk("t3_round", {28'd0, round}, 1);
    repeat (3) @(negedge clk);
    chk("t3_hold", {30'd0, lose, timeout}, 2);

    // 4: timeout, then match on the final timer cycle
    push_round(0);
    pulse_start();
    chk("t4_cleared", {31'd0, lose}, 0);
    wait_await();
    repeat (TOUT - 1) @(negedge clk);
    chk("t4_pre_to", {30'd0, await_play, lose}, 2);
    @(negedge clk);
    chk("t4_lose", {30'd0, lose, timeout}, 3);
    push_round(0);
    pulse_start();
    wait_await();
    repeat (TOUT - 1) @(negedge clk);
    push_round(1);
    play_valid = 1'b1; play_data = 4'b0001;
    @(negedge clk);
    play_valid = 1'b0; play_data = '0;
    chk("t4_accept", {29'd0, await_play, lose, timeout}, 0);

    // 5: finish rounds 1..3, start mid-game ignored, win then restart
    for (int r = 1; r <= LAST; r++) begin
      if (r == 2) begin
        wait (show_valid);
        pulse_start();
      end
      for (int i = 0; i <= r; i++) begin
        if (i == r && r < LAST) push_round(r + 1);
        enter(mem[i]);
      end
    end
    chk("t5_pre_win", {31'd0, win}, 0);
    @(negedge clk);
    chk("t5_win", {31'd0, win}, 1);
    chk("t5_round", {28'd0, round}, LAST);
    repeat (3) @(negedge clk);
    chk("t5_win_hold", {31'd0, win}, 1);
    push_round(0);
    pulse_start();
    chk("t5_win_clr", {31'd0, win}, 0);
    chk("t5_restart_round", {28'd0, round}, 0);
    wait_await();
    chk("t5_restart_await", {28'd0, round}, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
